fpu_norm_round_pipe: RTL

FPU_NORM_ROUND_PIPE -- requirements
Module: fpu_norm_round_pipe

---
 rtl/fpu_norm_round_pipe_if.sv | 31 +++
 rtl/fpu_norm_round_pipe.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fpu_norm_round_pipe_if.sv
// Stream bundle for the normalize/round pipeline: an unnormalized word in, a packed float out.
// The master side produces input words and consumes results; the slave side is the pipeline.
interface fpu_norm_round_pipe_if #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8,
    parameter int Extra_Bits    = 3
);
    localparam int W = Mantissa_Size + Extra_Bits + 2;

    logic                       in_valid;
    logic                       in_ready;
    logic                       in_sign;
    logic [W-1:0]               in_mantissa;
    logic signed [Exponent_Size+1:0] in_exponent;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_sign;
    logic [Mantissa_Size-1:0]   out_mantissa;
    logic [Exponent_Size-1:0]   out_exponent;
    logic [3:0]                 out_flags;

    modport master (
        output in_valid, in_sign, in_mantissa, in_exponent, out_ready,
        input  in_ready, out_valid, out_sign, out_mantissa, out_exponent, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_mantissa, in_exponent, out_ready,
        output in_ready, out_valid, out_sign, out_mantissa, out_exponent, out_flags
    );
endinterface

// File: rtl/fpu_norm_round_pipe.sv
// Two-stage float post-processing: stage N normalizes (carry shift or single-cycle LZC shift),
// stage R rounds to nearest-even and packs with overflow/underflow handling.
module fpu_norm_round_pipe #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8,
    parameter int Extra_Bits    = 3
) (
    input logic clk,
    input logic rst,
    fpu_norm_round_pipe_if.slave bus
);
    localparam int W  = Mantissa_Size + Extra_Bits + 2;
    localparam int EW = Exponent_Size + 2;
    localparam int LW = $clog2(W);
    localparam logic signed [EW:0] EXP_MAX = (EW+1)'((1 << Exponent_Size) - 1);

    // Stage N holds only the bits below the hidden one; the hidden bit is implicitly 1 unless zero.
    logic                   n_valid_reg;
    logic                   n_sign_reg;
    logic                   n_zero_reg;
    logic [W-3:0]           n_frac_reg;
    logic signed [EW-1:0]   n_exp_reg;

    logic                       out_valid_reg;
    logic                       out_sign_reg;
    logic [Mantissa_Size-1:0]   out_mantissa_reg;
    logic [Exponent_Size-1:0]   out_exponent_reg;
    logic [3:0]                 out_flags_reg;

    logic r_advance;
    logic n_advance;

    assign r_advance = !out_valid_reg || bus.out_ready;
    assign n_advance = !n_valid_reg || r_advance;

    logic [LW-1:0]          lzc;
    logic                   n_zero_next;
    logic [W-3:0]           n_frac_next;
    logic signed [EW-1:0]   n_exp_next;

    always_comb begin
        lzc = '0;
        for (int i = 0; i <= W-2; i++) begin
            if (bus.in_mantissa[i]) begin
                lzc = LW'(W - 2 - i);
            end
        end
        n_zero_next = (bus.in_mantissa == '0);
        n_frac_next = '0;
        n_exp_next  = '0;
        if (!n_zero_next) begin
            if (bus.in_mantissa[W-1]) begin
                // Carry out: drop one bit to the right, keeping it alive as sticky.
                n_frac_next = {bus.in_mantissa[W-2:2], |bus.in_mantissa[1:0]};
                n_exp_next  = bus.in_exponent + EW'(1);
            end else begin
                // Bits above the fraction field only move further up, so the low slice suffices.
                n_frac_next = bus.in_mantissa[W-3:0] << lzc;
                n_exp_next  = bus.in_exponent - EW'(lzc);
            end
        end
    end

    logic                       guard;
    logic                       sticky;
    logic                       lsb;
    logic                       round_up;
    logic [Mantissa_Size:0]     frac_sum;
    logic signed [EW:0]         exp_f;
    logic [Mantissa_Size-1:0]   r_mantissa_next;
    logic [Exponent_Size-1:0]   r_exponent_next;
    logic [3:0]                 r_flags_next;

    always_comb begin
        guard    = n_frac_reg[Extra_Bits-1];
        sticky   = |n_frac_reg[Extra_Bits-2:0];
        lsb      = n_frac_reg[Extra_Bits];
        round_up = guard & (sticky | lsb);
        // A carry out of the fraction leaves the fraction at zero and bumps the exponent.
        frac_sum = {1'b0, n_frac_reg[W-3:Extra_Bits]} + {{Mantissa_Size{1'b0}}, round_up};
        exp_f    = {n_exp_reg[EW-1], n_exp_reg} + {{EW{1'b0}}, frac_sum[Mantissa_Size]};

        r_mantissa_next = '0;
        r_exponent_next = '0;
        r_flags_next    = 4'b0000;
        if (n_zero_reg) begin
            r_flags_next = 4'b0001;
        end else if (exp_f[EW] || exp_f == '0) begin
            r_flags_next = 4'b0111;
        end else if (exp_f >= EXP_MAX) begin
            r_exponent_next = '1;
            r_flags_next    = 4'b1010;
        end else begin
            r_mantissa_next = frac_sum[Mantissa_Size-1:0];
            r_exponent_next = exp_f[Exponent_Size-1:0];
            r_flags_next    = {2'b00, guard | sticky, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_valid_reg      <= 1'b0;
            n_sign_reg       <= 1'b0;
            n_zero_reg       <= 1'b0;
            n_frac_reg       <= '0;
            n_exp_reg        <= '0;
            out_valid_reg    <= 1'b0;
            out_sign_reg     <= 1'b0;
            out_mantissa_reg <= '0;
            out_exponent_reg <= '0;
            out_flags_reg    <= '0;
        end else begin
            if (n_advance) begin
                n_valid_reg <= bus.in_valid;
                if (bus.in_valid) begin
                    n_sign_reg <= bus.in_sign;
                    n_zero_reg <= n_zero_next;
                    n_frac_reg <= n_frac_next;
                    n_exp_reg  <= n_exp_next;
                end
            end
            if (r_advance) begin
                out_valid_reg <= n_valid_reg;
                if (n_valid_reg) begin
                    out_sign_reg     <= n_sign_reg;
                    out_mantissa_reg <= r_mantissa_next;
                    out_exponent_reg <= r_exponent_next;
                    out_flags_reg    <= r_flags_next;
                end
            end
        end
    end

    assign bus.in_ready     = n_advance;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_sign     = out_sign_reg;
    assign bus.out_mantissa = out_mantissa_reg;
    assign bus.out_exponent = out_exponent_reg;
    assign bus.out_flags    = out_flags_reg;
endmodule
